l1d_evict_wr_adapter: RTL

Write-data adapter downstream of the L1D data-RAM pipe. Captures each evicted dirty line (`evict_en`/`evict_id`/`evict_dat`) into a small credit-managed buffer. Serialises each line into two TX DAT flits under CHI link-layer credits. Returns one buffer credit (`adp_crdv`) to the evict decoder and one `evict_done` to the MSHR per completed line.

---
 rtl/l1d_evict_wr_adapter_pkg.sv | 31 +++
 rtl/l1d_evict_wr_adapter_if.sv | 25 ++
 rtl/l1d_evict_wr_adapter_line_fifo.sv | 47 ++++
 rtl/l1d_evict_wr_adapter.sv | 90 +++++++++
 4 files changed

// File: rtl/l1d_evict_wr_adapter_pkg.sv
// l1d_package: shared types and constants for the L1D evict write-data adapter
//   pack_data_flit       - outgoing CHI DAT flit (fields not driven by the adapter stay 0)
//   pack_evict_buf_entry - one buffered evicted line {id, data}
//   adp_state_e          - send FSM states
package l1d_package;
   localparam int L1D_MSHR_ID_WIDTH = 4;
   localparam int L1D_LINE_W        = 512;
   localparam int L1D_BEAT_W        = 256;
   localparam int L1D_TXNID_W       = 12;
   localparam logic [3:0] L1D_OPC_CBWRDATA = 4'h2;
   typedef enum logic [1:0] {ADP_IDLE, ADP_BEAT0, ADP_BEAT1} adp_state_e;
   typedef struct packed {
      logic [L1D_MSHR_ID_WIDTH-1:0] id;
      logic [L1D_LINE_W-1:0]        data;
   } pack_evict_buf_entry;
   typedef struct packed {
      logic [3:0]              qos;
      logic [10:0]             tgt_id;
      logic [10:0]             src_id;
      logic [L1D_TXNID_W-1:0]  txn_id;
      logic [10:0]             home_nid;
      logic [3:0]              opcode;
      logic [1:0]              resp_err;
      logic [2:0]              resp;
      logic [11:0]             dbid;
      logic [1:0]              ccid;
      logic [1:0]              data_id;
      logic [L1D_BEAT_W/8-1:0] be;
      logic [L1D_BEAT_W-1:0]   data;
   } pack_data_flit;
endpackage

// File: rtl/l1d_evict_wr_adapter_if.sv
// l1d_evict_wr_adapter_if: evict capture, completion and TX DAT link signals of the write adapter
//   slave  - adapter view: takes evict_* and tx_dat_lcrdv, drives credits, completions and flits
//   master - environment view (evict decoder / MSHR / link receiver)
interface l1d_evict_wr_adapter_if;
   import l1d_package::*;
   logic                         evict_en;
   logic [L1D_MSHR_ID_WIDTH-1:0] evict_id;
   logic [L1D_LINE_W-1:0]        evict_dat;
   logic                         adp_crdv;
   logic                         evict_done_en;
   logic [L1D_MSHR_ID_WIDTH-1:0] evict_done_id;
   logic                         tx_dat_flitpend;
   logic                         tx_dat_flitv;
   pack_data_flit                tx_dat_flit;
   logic                         tx_dat_lcrdv;
   logic                         adp_err;
   modport slave (
      input  evict_en, evict_id, evict_dat, tx_dat_lcrdv,
      output adp_crdv, evict_done_en, evict_done_id, tx_dat_flitpend, tx_dat_flitv, tx_dat_flit, adp_err
   );
   modport master (
      output evict_en, evict_id, evict_dat, tx_dat_lcrdv,
      input  adp_crdv, evict_done_en, evict_done_id, tx_dat_flitpend, tx_dat_flitv, tx_dat_flit, adp_err
   );
endinterface

// File: rtl/l1d_evict_wr_adapter_line_fifo.sv
// l1d_evict_line_fifo: circular buffer of evicted lines with occupancy count
//   clk, rst_n    - clock, asynchronous active-low reset
//   push, wdata   - enqueue at wr_ptr
//   pop, rdata    - dequeue at rd_ptr; rdata is the current head
//   cnt, cnt_nxt  - occupancy now and after this edge
//   full, empty   - occupancy flags
module l1d_evict_line_fifo
   import l1d_package::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push,
   input  pack_evict_buf_entry         wdata,
   input  logic                        pop,
   output pack_evict_buf_entry         rdata,
   output logic [$clog2(DEPTH+1)-1:0]  cnt,
   output logic [$clog2(DEPTH+1)-1:0]  cnt_nxt,
   output logic                        full,
   output logic                        empty
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   pack_evict_buf_entry mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   // explicit wrap so non-power-of-two depths stay modulo DEPTH
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   assign rdata   = mem[rd_ptr];
   assign full    = cnt == CW'(DEPTH);
   assign empty   = cnt == '0;
   assign cnt_nxt = cnt + CW'(push) - CW'(pop);
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wdata;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop) rd_ptr <= nxt(rd_ptr);
         cnt <= cnt_nxt;
      end
endmodule

// File: rtl/l1d_evict_wr_adapter.sv
// l1d_evict_wr_adapter: buffers evicted dirty lines and sends each as two CHI TX DAT flits under link credits
//   clk, rst_n      - clock, asynchronous active-low reset
//   bus (slave)     - evict_en/id/dat in; adp_crdv, evict_done_en/id, tx_dat_flitpend/flitv/flit out;
//                     tx_dat_lcrdv in; adp_err out
//   Optional: define L1D_WR_ADP_ERR_CHK_EN for the sticky adp_err overflow checks (else adp_err = 0).
module l1d_evict_wr_adapter
   import l1d_package::*;
#(
   parameter int BUF_DEPTH = 4,
   parameter int LINE_W    = 512,
   parameter int BEAT_W    = 256,
   parameter int LCRD_MAX  = 15
) (
   input logic                   clk,
   input logic                   rst_n,
   l1d_evict_wr_adapter_if.slave bus
);
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int LW = $clog2(LCRD_MAX + 1);
   localparam logic [LW-1:0] LMAX = LW'(LCRD_MAX);
   adp_state_e                   state, state_nxt;
   logic [LW-1:0]                lcrd_cnt;
   logic [CW-1:0]                cnt, cnt_nxt;
   logic                         full, empty, push, pop, send, lcrd_ovf, lcrd_inc, dq;
   logic [L1D_MSHR_ID_WIDTH-1:0] dq_id;
   pack_evict_buf_entry          wr_ent, head;
   pack_data_flit                flit_d;

   assign wr_ent = '{id: bus.evict_id, data: bus.evict_dat};
   // a write into a full buffer is dropped so the pointers never overrun
   assign push = bus.evict_en && !full;

   l1d_evict_line_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push), .wdata(wr_ent), .pop(pop), .rdata(head),
      .cnt(cnt), .cnt_nxt(cnt_nxt), .full(full), .empty(empty)
   );

   // IDLE with a line waiting sends beat0 directly, giving the two-cycle evict-to-flit latency
   assign send = lcrd_cnt != '0 && (state != ADP_IDLE || !empty);
   assign pop  = send && state == ADP_BEAT1;
   assign state_nxt = send ? (state != ADP_BEAT1 ? ADP_BEAT1 : |cnt[CW-1:1] ? ADP_BEAT0 : ADP_IDLE)
                           : (state == ADP_IDLE && !empty ? ADP_BEAT0 : state);
   // a credit arriving at the ceiling is absorbed unless a flit consumes one in the same cycle
   assign lcrd_ovf = bus.tx_dat_lcrdv && lcrd_cnt == LMAX;
   assign lcrd_inc = bus.tx_dat_lcrdv && (!lcrd_ovf || send);

   always_comb begin
      flit_d = '0;
      flit_d.opcode = L1D_OPC_CBWRDATA;
      flit_d.txn_id[L1D_MSHR_ID_WIDTH-1:0] = head.id;
      flit_d.data_id = state == ADP_BEAT1 ? 2'b10 : 2'b00;
      flit_d.data = state == ADP_BEAT1 ? head.data[LINE_W-1:BEAT_W] : head.data[BEAT_W-1:0];
   end

   // dq/dq_id stage the dequeue so the credit and completion appear one cycle after beat1
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state                <= ADP_IDLE;
         lcrd_cnt             <= '0;
         dq                   <= 1'b0;
         dq_id                <= '0;
         bus.tx_dat_flitv     <= 1'b0;
         bus.tx_dat_flit      <= '0;
         bus.tx_dat_flitpend  <= 1'b0;
         bus.adp_crdv         <= 1'b0;
         bus.evict_done_en    <= 1'b0;
         bus.evict_done_id    <= '0;
      end else begin
         state                <= state_nxt;
         lcrd_cnt             <= lcrd_cnt + LW'(lcrd_inc) - LW'(send);
         dq                   <= pop;
         dq_id                <= head.id;
         bus.tx_dat_flitv     <= send;
         bus.tx_dat_flit      <= send ? flit_d : '0;
         bus.tx_dat_flitpend  <= cnt_nxt != '0;
         bus.adp_crdv         <= dq;
         bus.evict_done_en    <= dq;
         bus.evict_done_id    <= dq ? dq_id : '0;
      end

`ifdef L1D_WR_ADP_ERR_CHK_EN
   logic err;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err <= 1'b0;
      else if ((bus.evict_en && full) || lcrd_ovf) err <= 1'b1;
   assign bus.adp_err = err;
`else
   assign bus.adp_err = 1'b0;
`endif
endmodule
